// File: rtl/wubsuit_base.sv
// wubsuit_base: seven debounced body triggers -> MIDI Note On/Off on MIDI_TX (mirrored on XBee_TX);
// MIDI_RX echoed to UART_0_TXD, UART_0_RXD passed to LCD_TX. Define XBEE_REMOTE_EN to queue XBee_RX bytes for MIDI_TX.
// Latency: DEBOUNCE_CYC+~4 clocks trigger-to-start-bit; echo paths are one frame plus ~4 clocks. Full TX holding registers drop echo bytes.

// wub_tx: 8N1 serial transmitter with a 1-byte holding register.
// Latency: start bit 1 clock after the holding register fills while the shifter is idle.
// Backpressure: ld is ignored while the holding register is full and the shifter busy (byte dropped).
module wub_tx #(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [7:0] dat,
  output logic       line,
  output logic       idle
);
  logic [7:0]  hold;
  logic        hold_vld;
  logic        busy;
  logic [8:0]  sh;
  logic [3:0]  bitn;
  logic [15:0] cnt;

  assign idle = !busy && !hold_vld;

  // holding register feeds a shifter; start bit driven directly, {stop,data} shifted out LSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      line     <= 1'b1;
      busy     <= 1'b0;
      hold_vld <= 1'b0;
      hold     <= '0;
      sh       <= '1;
      bitn     <= '0;
      cnt      <= '0;
    end else begin
      if (!busy && hold_vld) begin
        sh       <= {1'b1, hold};
        line     <= 1'b0;
        busy     <= 1'b1;
        hold_vld <= 1'b0;
        bitn     <= '0;
        cnt      <= '0;
      end else if (busy) begin
        if (cnt == 16'(DIV - 1)) begin
          cnt <= '0;
          if (bitn == 4'd9) begin
            busy <= 1'b0;
          end else begin
            line <= sh[0];
            sh   <= {1'b1, sh[8:1]};
            bitn <= bitn + 4'd1;
          end
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
      // a slot is free if empty, or if the shifter takes the held byte this cycle
      if (ld && (!hold_vld || !busy)) begin
        hold     <= dat;
        hold_vld <= 1'b1;
      end
    end
  end
endmodule

// wub_rx: 8N1 serial receiver, 2-FF synchronised, mid-bit sampling.
// Latency: vld 1 clock after the mid-stop-bit sample.
// Backpressure: none; bytes with a low stop bit are discarded.
module wub_rx #(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       vld,
  output logic [7:0] dat
);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;
  rstate_t     st;
  logic        s0, s1, s2;
  logic [15:0] cnt;
  logic [2:0]  bitn;
  logic [7:0]  sh;

  // synchroniser, falling-edge start detect confirmed at mid start bit, then mid-bit sampling
  always_ff @(posedge clk) begin
    if (rst) begin
      s0   <= 1'b1;
      s1   <= 1'b1;
      s2   <= 1'b1;
      st   <= R_IDLE;
      cnt  <= '0;
      bitn <= '0;
      sh   <= '0;
      vld  <= 1'b0;
      dat  <= '0;
    end else begin
      s0  <= rx;
      s1  <= s0;
      s2  <= s1;
      vld <= 1'b0;
      case (st)
        R_IDLE: if (s2 && !s1) begin
          st  <= R_START;
          cnt <= '0;
        end
        R_START: if (cnt == 16'(DIV / 2 - 1)) begin
          cnt  <= '0;
          bitn <= '0;
          st   <= s1 ? R_IDLE : R_DATA;
        end else cnt <= cnt + 16'd1;
        R_DATA: if (cnt == 16'(DIV - 1)) begin
          cnt <= '0;
          sh  <= {s1, sh[7:1]};
          if (bitn == 3'd7) st <= R_STOP;
          else bitn <= bitn + 3'd1;
        end else cnt <= cnt + 16'd1;
        R_STOP: if (cnt == 16'(DIV - 1)) begin
          cnt <= '0;
          st  <= R_IDLE;
          if (s1) begin
            vld <= 1'b1;
            dat <= sh;
          end
        end else cnt <= cnt + 16'd1;
        default: st <= R_IDLE;
      endcase
    end
  end
endmodule

// wubsuit_base: trigger debounce, fixed-priority Note On/Off arbiter and serial routing.
// Latency: message starts once both MIDI and XBee shifters are idle; bytes are spaced by the slower shifter.
// Backpressure: pending events wait for idle shifters; echo and FIFO bytes drop when their target is full.
module wubsuit_base #(
  parameter int MIDI_DIV     = 320,
  parameter int XBEE_DIV     = 1042,
  parameter int UART0_DIV    = 87,
  parameter int LCD_DIV      = 1042,
  parameter int DEBOUNCE_CYC = 10000,
  parameter int MIDI_CH      = 0,
  parameter int VELOCITY     = 100
) (
  input  logic SYSCLK,
  input  logic SYSRESET,
  input  logic UART_0_RXD,
  input  logic XBee_RX,
  input  logic MIDI_RX,
  input  logic RPiezo,
  input  logic LPiezo,
  input  logic CapButton,
  input  logic CButton0,
  input  logic CButton1,
  input  logic CButton2,
  input  logic CButton3,
  output logic UART_0_TXD,
  output logic XBee_TX,
  output logic LCD_TX,
  output logic MIDI_TX,
  output logic RXRDY
);
  localparam int NSRC = 7;
  typedef enum logic [1:0] {S_IDLE, S_B0, S_B1, S_B2} mstate_t;

  logic            clk, rst;
  logic [NSRC-1:0] trig, t0, t1, deb, pend_on, pend_off;
  logic [15:0]     dcnt [NSRC];
  mstate_t         st;
  logic [2:0]      sel_idx;
  logic            sel_off, any_pend, quiet, start_loc;
  logic            ld_loc, ld_fifo;
  logic [7:0]      ld_dat, b_stat, b_note, b_vel;
  logic            midi_idle, xbee_idle, uart0_idle, lcd_idle;
  logic            mrx_vld, urx_vld, xrx_vld;
  logic [7:0]      mrx_dat, urx_dat, xrx_dat;

  assign clk   = SYSCLK;
  assign rst   = SYSRESET;
  assign trig  = {CButton3, CButton2, CButton1, CButton0, CapButton, LPiezo, RPiezo};
  assign RXRDY = urx_vld;

  function automatic logic [7:0] note_of(input logic [2:0] i);
    case (i)
      3'd0:    note_of = 8'd38;
      3'd1:    note_of = 8'd36;
      3'd2:    note_of = 8'd42;
      3'd3:    note_of = 8'd60;
      3'd4:    note_of = 8'd61;
      3'd5:    note_of = 8'd62;
      default: note_of = 8'd63;
    endcase
  endfunction

  // pick highest-priority event: any off before any on, lowest source index first
  always_comb begin
    sel_off  = 1'b0;
    sel_idx  = '0;
    any_pend = |pend_on || |pend_off;
    for (int i = NSRC - 1; i >= 0; i--) if (pend_on[i]) sel_idx = 3'(i);
    if (|pend_off) begin
      sel_off = 1'b1;
      for (int i = NSRC - 1; i >= 0; i--) if (pend_off[i]) sel_idx = 3'(i);
    end
  end

  assign quiet     = !ld_loc && !ld_fifo;
  assign start_loc = (st == S_IDLE) && quiet && midi_idle && xbee_idle && any_pend;

  // sync + debounce each trigger; accepted edges replace that source's pending event
  always_ff @(posedge clk) begin
    if (rst) begin
      t0       <= '0;
      t1       <= '0;
      deb      <= '0;
      pend_on  <= '0;
      pend_off <= '0;
      for (int i = 0; i < NSRC; i++) dcnt[i] <= '0;
    end else begin
      t0 <= trig;
      t1 <= t0;
      if (start_loc) begin
        if (sel_off) pend_off[sel_idx] <= 1'b0;
        else         pend_on[sel_idx]  <= 1'b0;
      end
      for (int i = 0; i < NSRC; i++) begin
        if (t1[i] != deb[i]) begin
          if (dcnt[i] == 16'(DEBOUNCE_CYC - 1)) begin
            dcnt[i]     <= '0;
            deb[i]      <= t1[i];
            pend_on[i]  <= t1[i];
            pend_off[i] <= !t1[i];
          end else dcnt[i] <= dcnt[i] + 16'd1;
        end else dcnt[i] <= '0;
      end
    end
  end

`ifdef XBEE_REMOTE_EN
  logic [7:0] fmem [4];
  logic [1:0] wp, rp;
  logic [2:0] fcnt;
  logic       fifo_start, fpush;

  assign fifo_start = (st == S_IDLE) && quiet && midi_idle && !any_pend && (fcnt != 3'd0);
  assign fpush      = xrx_vld && (fcnt != 3'd4);

  // 4-entry queue of remote bytes; a byte arriving while full is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      if (fpush) begin
        fmem[wp] <= xrx_dat;
        wp       <= wp + 2'd1;
      end
      if (fifo_start) rp <= rp + 2'd1;
      fcnt <= fcnt + 3'(fpush) - 3'(fifo_start);
    end
  end
`else
  logic xbee_unused;
  assign xbee_unused = ^{xrx_vld, xrx_dat};
  assign ld_fifo     = 1'b0;
`endif

  // message sequencer: latch event, then issue 3 bytes, each once both shifters are idle
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= S_IDLE;
      ld_loc <= 1'b0;
      ld_dat <= '0;
      b_stat <= '0;
      b_note <= '0;
      b_vel  <= '0;
`ifdef XBEE_REMOTE_EN
      ld_fifo <= 1'b0;
`endif
    end else begin
      ld_loc <= 1'b0;
`ifdef XBEE_REMOTE_EN
      ld_fifo <= 1'b0;
`endif
      case (st)
        S_IDLE: if (start_loc) begin
          b_stat <= {(sel_off ? 4'h8 : 4'h9), 4'(MIDI_CH)};
          b_note <= note_of(sel_idx);
          b_vel  <= sel_off ? 8'h00 : {1'b0, 7'(VELOCITY)};
          st     <= S_B0;
        end
`ifdef XBEE_REMOTE_EN
        else if (fifo_start) begin
          ld_fifo <= 1'b1;
          ld_dat  <= fmem[rp];
        end
`endif
        S_B0: if (quiet && midi_idle && xbee_idle) begin
          ld_loc <= 1'b1;
          ld_dat <= b_stat;
          st     <= S_B1;
        end
        S_B1: if (quiet && midi_idle && xbee_idle) begin
          ld_loc <= 1'b1;
          ld_dat <= b_note;
          st     <= S_B2;
        end
        default: if (quiet && midi_idle && xbee_idle) begin
          ld_loc <= 1'b1;
          ld_dat <= b_vel;
          st     <= S_IDLE;
        end
      endcase
    end
  end

  wub_tx #(.DIV(MIDI_DIV))  u_midi_tx  (.clk(clk), .rst(rst), .ld(ld_loc | ld_fifo), .dat(ld_dat),  .line(MIDI_TX),    .idle(midi_idle));
  wub_tx #(.DIV(XBEE_DIV))  u_xbee_tx  (.clk(clk), .rst(rst), .ld(ld_loc),           .dat(ld_dat),  .line(XBee_TX),    .idle(xbee_idle));
  wub_tx #(.DIV(UART0_DIV)) u_uart0_tx (.clk(clk), .rst(rst), .ld(mrx_vld),          .dat(mrx_dat), .line(UART_0_TXD), .idle(uart0_idle));
  wub_tx #(.DIV(LCD_DIV))   u_lcd_tx   (.clk(clk), .rst(rst), .ld(urx_vld),          .dat(urx_dat), .line(LCD_TX),     .idle(lcd_idle));

  wub_rx #(.DIV(MIDI_DIV))  u_midi_rx  (.clk(clk), .rst(rst), .rx(MIDI_RX),    .vld(mrx_vld), .dat(mrx_dat));
  wub_rx #(.DIV(UART0_DIV)) u_uart0_rx (.clk(clk), .rst(rst), .rx(UART_0_RXD), .vld(urx_vld), .dat(urx_dat));
  wub_rx #(.DIV(XBEE_DIV))  u_xbee_rx  (.clk(clk), .rst(rst), .rx(XBee_RX),    .vld(xrx_vld), .dat(xrx_dat));

  logic idle_unused;
  assign idle_unused = uart0_idle ^ lcd_idle;
endmodule

// File: tb/tb_wubsuit_base.sv
// tb_wubsuit_base: scoreboard bench for wubsuit_base with shortened bit periods and debounce.
// Stimulus pushes expected bytes per output line; one decoder process per line pops and compares.
module tb_wubsuit_base;
  localparam int MD = 8, XD = 16, UD = 6, LD = 10, DEB = 20;

  logic SYSCLK = 1'b0, SYSRESET = 1'b1;
  logic UART_0_RXD = 1'b1, XBee_RX = 1'b1, MIDI_RX = 1'b1;
  logic RPiezo = 1'b0, LPiezo = 1'b0, CapButton = 1'b0;
  logic CButton0 = 1'b0, CButton1 = 1'b0, CButton2 = 1'b0, CButton3 = 1'b0;
  logic UART_0_TXD, XBee_TX, LCD_TX, MIDI_TX, RXRDY;

  always #5 SYSCLK = ~SYSCLK;

  wubsuit_base #(
    .MIDI_DIV(MD), .XBEE_DIV(XD), .UART0_DIV(UD), .LCD_DIV(LD),
    .DEBOUNCE_CYC(DEB), .MIDI_CH(0), .VELOCITY(100)
  ) dut (
    .SYSCLK(SYSCLK), .SYSRESET(SYSRESET), .UART_0_RXD(UART_0_RXD), .XBee_RX(XBee_RX),
    .MIDI_RX(MIDI_RX), .RPiezo(RPiezo), .LPiezo(LPiezo), .CapButton(CapButton),
    .CButton0(CButton0), .CButton1(CButton1), .CButton2(CButton2), .CButton3(CButton3),
    .UART_0_TXD(UART_0_TXD), .XBee_TX(XBee_TX), .LCD_TX(LCD_TX), .MIDI_TX(MIDI_TX), .RXRDY(RXRDY)
  );

  int         vectors = 0, miscompares = 0, rxrdy_cnt = 0;
  int         nbytes [4] = '{default: 0};
  logic [7:0] expq [4][$];

  function automatic logic line_of(input int w);
    case (w)
      0:       line_of = MIDI_TX;
      1:       line_of = XBee_TX;
      2:       line_of = UART_0_TXD;
      default: line_of = LCD_TX;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // decode one 8N1 frame per falling edge and compare against the line's queue
  task automatic mon(input int w, input int div, input string name);
    logic [7:0] b;
    logic       stp;
    logic [7:0] e;
    forever begin
      @(negedge SYSCLK);
      if (!SYSRESET && line_of(w) === 1'b0) begin
        repeat (div / 2) @(negedge SYSCLK);
        for (int i = 0; i < 8; i++) begin
          repeat (div) @(negedge SYSCLK);
          b[i] = line_of(w);
        end
        repeat (div) @(negedge SYSCLK);
        stp = line_of(w);
        nbytes[w]++;
        if (expq[w].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL %s unexpected byte: got %0h, expected none", name, b);
        end else begin
          e = expq[w].pop_front();
          check(name, {23'd0, stp, b}, {23'd0, 1'b1, e});
        end
      end
    end
  endtask

  initial mon(0, MD, "midi_tx");
  initial mon(1, XD, "xbee_tx");
  initial mon(2, UD, "uart0_tx");
  initial mon(3, LD, "lcd_tx");

  initial forever begin
    @(negedge SYSCLK);
    if (RXRDY === 1'b1) rxrdy_cnt++;
  end

  task automatic push_msg(input logic on, input logic [7:0] note);
    logic [7:0] m [3];
    m[0] = on ? 8'h90 : 8'h80;
    m[1] = note;
    m[2] = on ? 8'h64 : 8'h00;
    for (int i = 0; i < 3; i++) begin
      expq[0].push_back(m[i]);
      expq[1].push_back(m[i]);
    end
  endtask

  task automatic set_rx(input int w, input logic v);
    case (w)
      0:       MIDI_RX = v;
      1:       UART_0_RXD = v;
      default: XBee_RX = v;
    endcase
  endtask

  task automatic send_ser(input int w, input int div, input logic [7:0] b, input logic stp);
    logic [9:0] f;
    f = {stp, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_rx(w, f[i]);
      repeat (div) @(negedge SYSCLK);
    end
    set_rx(w, 1'b1);
    repeat (div * 2) @(negedge SYSCLK);
  endtask

  task automatic wait_drain(input string name);
    int k;
    int left;
    k = 0;
    left = expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size();
    while (left != 0 && k < 4000) begin
      @(negedge SYSCLK);
      k++;
      left = expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size();
    end
    vectors++;
    if (left != 0) begin
      miscompares++;
      $display("FAIL %s timeout: %0d bytes still outstanding, expected 0", name, left);
    end
    repeat (40) @(negedge SYSCLK);
  endtask

  initial begin
    int r0, n0;
    repeat (10) @(negedge SYSCLK);
    check("rst_midi_tx",  {31'd0, MIDI_TX},    32'd1);
    check("rst_xbee_tx",  {31'd0, XBee_TX},    32'd1);
    check("rst_uart0_tx", {31'd0, UART_0_TXD}, 32'd1);
    check("rst_lcd_tx",   {31'd0, LCD_TX},     32'd1);
    check("rst_rxrdy",    {31'd0, RXRDY},      32'd0);
    SYSRESET = 1'b0;
    r0 = rxrdy_cnt;
    repeat (100) @(negedge SYSCLK);
    check("idle_lines", {28'd0, MIDI_TX, XBee_TX, UART_0_TXD, LCD_TX}, 32'hF);
    check("idle_rxrdy", 32'(rxrdy_cnt - r0), 32'd0);

    // right piezo on, then off
    push_msg(1'b1, 8'h26);
    RPiezo = 1'b1;
    repeat (60) @(negedge SYSCLK);
    wait_drain("rpiezo_on");
    push_msg(1'b0, 8'h26);
    RPiezo = 1'b0;
    wait_drain("rpiezo_off");

    // glitch shorter than the debounce window
    n0 = nbytes[0];
    RPiezo = 1'b1;
    repeat (DEB / 2) @(negedge SYSCLK);
    RPiezo = 1'b0;
    repeat (600) @(negedge SYSCLK);
    check("glitch_no_msg", 32'(nbytes[0] - n0), 32'd0);

    // simultaneous rise: LPiezo outranks CButton2
    push_msg(1'b1, 8'h24);
    push_msg(1'b1, 8'h3E);
    LPiezo = 1'b1;
    CButton2 = 1'b1;
    wait_drain("lp_cb2_on");
    push_msg(1'b0, 8'h24);
    push_msg(1'b0, 8'h3E);
    LPiezo = 1'b0;
    CButton2 = 1'b0;
    wait_drain("lp_cb2_off");

    // off events go first even from a lower-priority source
    push_msg(1'b1, 8'h3C);
    CButton0 = 1'b1;
    wait_drain("cb0_on");
    push_msg(1'b0, 8'h3C);
    push_msg(1'b1, 8'h24);
    CButton0 = 1'b0;
    LPiezo = 1'b1;
    wait_drain("off_before_on");
    push_msg(1'b0, 8'h24);
    LPiezo = 1'b0;
    wait_drain("lp_off");

    // MIDI_RX echo to console, framing error dropped
    expq[2].push_back(8'h5A);
    send_ser(0, MD, 8'h5A, 1'b1);
    wait_drain("midi_echo");
    n0 = nbytes[2];
    send_ser(0, MD, 8'hC3, 1'b0);
    repeat (200) @(negedge SYSCLK);
    check("midi_rx_frame_err", 32'(nbytes[2] - n0), 32'd0);

    // console RX to LCD with a single RXRDY pulse
    r0 = rxrdy_cnt;
    expq[3].push_back(8'h41);
    send_ser(1, UD, 8'h41, 1'b1);
    wait_drain("lcd_pass");
    check("rxrdy_once", 32'(rxrdy_cnt - r0), 32'd1);
    r0 = rxrdy_cnt;
    n0 = nbytes[3];
    send_ser(1, UD, 8'h7E, 1'b0);
    repeat (200) @(negedge SYSCLK);
    check("rxrdy_frame_err", 32'(rxrdy_cnt - r0), 32'd0);
    check("lcd_frame_err", 32'(nbytes[3] - n0), 32'd0);

    // remote byte arriving mid-message
    push_msg(1'b1, 8'h26);
`ifdef XBEE_REMOTE_EN
    expq[0].push_back(8'hF8);
`endif
    RPiezo = 1'b1;
    repeat (DEB + 6) @(negedge SYSCLK);
    send_ser(2, XD, 8'hF8, 1'b1);
    wait_drain("xbee_remote");
    push_msg(1'b0, 8'h26);
    RPiezo = 1'b0;
    wait_drain("rpiezo_off2");

    repeat (200) @(negedge SYSCLK);
    for (int w = 0; w < 4; w++) check("leftover_q", 32'(expq[w].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
